// File: rtl/common.sv
`default_nettype none
// ============================================================================
// Package : common
// Core memory bus (cbus) request/response types and field encodings.
// Rev     : 1.0 - initial release
// ============================================================================
package common;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  // len holds the beat count minus one, so 0 is a single-beat transaction
  typedef logic [3:0] cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/pipes.sv
`default_nettype none
// ============================================================================
// Package : pipes
// Pipeline-side control types shared by the cbus arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package pipes;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/cbus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : cbus_arbiter_if
// Requester-side and bus-side signals of the cbus arbiter.
// Rev       : 1.0 - initial release
// ============================================================================
interface cbus_arbiter_if
  import common::*;
#(
  parameter int N = 2
) ();

  cbus_req_t              ireqs  [N];
  cbus_resp_t             iresps [N];
  cbus_req_t              oreq;
  cbus_resp_t             oresp;
  logic                   busy;
  logic [$clog2(N)-1:0]   grant_idx;

  // master: the arbiter; slave: requesters plus the bus slave around it
  modport master (
    input  ireqs, oresp,
    output iresps, oreq, busy, grant_idx
  );

  modport slave (
    output ireqs, oresp,
    input  iresps, oreq, busy, grant_idx
  );

endinterface
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module : rr_select
// Combinational winner select: rotating priority after last_i, or fixed
// lowest-index priority when mode_i is 0.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_select #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  input  logic          mode_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  logic [IW:0] cand;

  always_comb begin
    winner_o = '0;
    any_o    = |valid_i;
    cand     = '0;
    if (mode_i) begin
      // Scan farthest offset first so the nearest valid index after last_i wins
      for (int k = N; k >= 1; k--) begin
        cand = {1'b0, last_i} + (IW+1)'(k);
        if (cand >= (IW+1)'(N)) begin
          cand = cand - (IW+1)'(N);
        end
        if (valid_i[cand[IW-1:0]]) begin
          winner_o = cand[IW-1:0];
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (valid_i[i]) begin
          winner_o = IW'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cbus_arbiter
// Grants the shared cbus to one requester per whole transaction and routes
// the bus response back to the granted requester only.
// Rev    : 1.0 - initial release
// ============================================================================
module cbus_arbiter
  import common::*;
  import pipes::*;
#(
  parameter int N           = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  cbus_arbiter_if.master bus
);

  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  LAST_RST = IW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  valid_vec;
  logic [IW-1:0] winner;
  logic          any_valid;

  for (genvar i = 0; i < N; i++) begin : g_valid
    assign valid_vec[i] = bus.ireqs[i].valid;
  end

  rr_select #(
    .N  (N),
    .IW (IW)
  ) u_rr_select (
    .valid_i  (valid_vec),
    .last_i   (last_q),
    .mode_i   (ROUND_ROBIN),
    .winner_o (winner),
    .any_o    (any_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    bus.oreq      = '0;
    bus.busy      = 1'b0;
    bus.grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      bus.iresps[i] = '0;
    end

    // Outputs are forced quiet while reset is held, even if still BUSY
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            idx_d   = winner;
            state_d = BUSY;
          end
        end
        BUSY: begin
          bus.oreq          = bus.ireqs[idx_q];
          bus.iresps[idx_q] = bus.oresp;
          bus.busy          = 1'b1;
          bus.grant_idx     = idx_q;
          if (bus.oresp.ready && bus.oresp.last) begin
            state_d = IDLE;
            last_d  = idx_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
Shares the single core memory bus (cbus) between N pipeline requesters: index 0 is instruction fetch, index 1 is data memory. The block grants one whole transaction at a time and holds the grant until the final beat completes. It passes the granted request to the bus and routes the bus response back to the granted requester only. It sits between the fetch/memory stages and the cbus port. Requesters that are not granted see ready=0 and stall through the hazard logic.

Parameters:
N, 2, number of requesters (2..8)
ROUND_ROBIN, 1, 1 = rotating priority after each transaction; 0 = fixed priority, lowest index wins

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
ireqs  in  N x cbus_req_t  requests {valid, is_write, size[2:0], addr[63:0], strobe[7:0], data[63:0], len[3:0]}
iresps  out  N x cbus_resp_t  responses {ready, last, data[63:0]}
oreq  out  cbus_req_t  request driven onto the shared bus
oresp  in  cbus_resp_t  response from the shared bus
busy  out  1  a transaction is granted
grant_idx  out  $clog2(N)  index of the granted requester; valid only while busy=1

Behaviour:
- FSM with two states, IDLE and BUSY. Registers: state, idx (granted index), last (index of the previous grant).
- Reset (synchronous, priority over everything, including mid-transaction):
  - state=IDLE, idx=0, last=N-1.
  - Outputs during and after reset: oreq all-zero (valid=0), every iresps all-zero, busy=0, grant_idx=0.
  - An aborted in-flight transaction is dropped. The bus slave must also be reset.
- IDLE:
  - oreq all-zero, iresps all-zero.
  - If any ireqs[i].valid, the winner is chosen combinationally:
    - ROUND_ROBIN=1: the first valid index scanning last+1, last+2, ... modulo N.
    - ROUND_ROBIN=0: the lowest valid index.
  - Next edge: idx=winner, state=BUSY. No grant if no request is valid.
- BUSY:
  - oreq = ireqs[idx], passed through combinationally.
  - iresps[idx] = oresp. All other iresps are all-zero.
  - busy=1, grant_idx=idx.
  - When oresp.ready && oresp.last: next edge state=IDLE, last=idx.
- Latency:
  - valid to oreq.valid is 1 cycle.
  - One mandatory IDLE bubble separates back-to-back transactions, so the minimum gap between transactions is 1 cycle.
- Requester protocol: after asserting valid, a requester holds every request field stable until it sees ready && last. The arbiter does not check this. If valid drops mid-transaction, the grant is still held until last. oreq.valid then follows the requester's signal, which is a protocol violation, and the bench flags it.
- Multi-beat transactions (len>0): one grant covers all beats. Beats with ready=1 and last=0 keep the state at BUSY.
- A request arriving while BUSY waits. It cannot preempt the current transaction and is evaluated in the next IDLE cycle.
- If oresp.ready/last arrive while in IDLE (spurious), they are ignored and not forwarded.
- Starvation: with ROUND_ROBIN=1, any continuously valid requester is granted within N transactions.
- Widths: index arithmetic is modulo N. For non-power-of-two N, wrap explicitly; do not use natural overflow.

Decomposition:
- Package `common`: cbus_req_t, cbus_resp_t, and size/len encodings.
- Package `pipes`: the arbiter state enum {IDLE, BUSY}.
- One sub-module `rr_select` (combinational):
  - Inputs: valid vector, last, mode.
  - Outputs: winner index, any.
  - Instantiated once. The FSM and muxing stay in cbus_arbiter.

Test Plan:
- Single request: reset, then ireqs[1].valid with addr=0x80001000, len=0. Response: oreq.valid=1 one cycle later. oresp ready=last=1 with data=0xDEAD is forwarded to iresps[1] only, and busy=0 the next cycle.
- Contention, round-robin (N=2): both valid continuously, 3 single-beat transactions. Grant order is 0, 1, 0 (last=1 after reset). Each transaction is separated by exactly one IDLE cycle.
- Fixed priority: ROUND_ROBIN=0, both valid continuously for 3 transactions. All 3 are granted to index 0, and iresps[1].ready stays 0 throughout.
- Burst: ireqs[0] with len=3, slave returns 4 beats, last on the 4th. A ireqs[1] request raised during beat 2 is granted only after the 4th beat. No beat of that burst is routed to index 1.
- Reset mid-transaction: assert reset in BUSY during beat 2 of a burst. The next cycle shows oreq.valid=0, busy=0, and all iresps zero. After reset is released with requester 0 valid, index 0 is granted.
- Spurious response: oresp ready=last=1 while IDLE with no requests. All iresps stay zero and the state stays IDLE.
